// File: rtl/weight_stream_ctrl_pkg.sv
// Shared types and helpers for the weight_stream_ctrl ROM-to-stream sequencer.
package weight_stream_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam int unsigned DefCoeffWidth = 16;
    localparam int unsigned PassWidth     = 16;

    // ROM address width; a single-entry ROM still gets one address bit.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weight_stream_ctrl_skid_buf.sv
// Two-entry FIFO between the ROM read port and the output stream; entry 0 is always the head.
module weight_stream_ctrl_skid_buf #(
    parameter int unsigned Width = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [Width-1:0] i_din,
    output logic [Width-1:0] o_dout,
    output logic [1:0]       o_occ
);

    logic [Width-1:0] r_e0;
    logic [Width-1:0] r_e1;
    logic [1:0]       r_occ;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_e0  <= '0;
            r_e1  <= '0;
            r_occ <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_e0 <= i_din;
                    end else if (r_occ == 2'd1) begin
                        r_e1 <= i_din;
                    end
                end
                2'b01: begin
                    // Head holds its value once the buffer drains.
                    if (r_occ == 2'd2) begin
                        r_e0 <= r_e1;
                    end
                end
                2'b11: begin
                    if (r_occ == 2'd2) begin
                        r_e0 <= r_e1;
                        r_e1 <= i_din;
                    end else begin
                        r_e0 <= i_din;
                    end
                end
                default: ;
            endcase
            r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_dout = r_e0;
    assign o_occ  = r_occ;

endmodule

// File: rtl/weight_stream_ctrl.sv
// Sweeps a coefficient ROM NUM_PASSES times per start into an ap_fifo stream.
// Optional WEIGHT_CTRL_PERF_EN adds the stall_cycles back-pressure counter.
module weight_stream_ctrl
    import weight_stream_ctrl_pkg::*;
#(
    parameter int unsigned KERN_SIZE   = 288,
    parameter int unsigned COEFF_WIDTH = DefCoeffWidth,
    parameter int unsigned NUM_PASSES  = 1,
    localparam int unsigned AddrW      = addr_width(KERN_SIZE)
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic                   ap_start,
    output logic                   ap_done,
    output logic                   ap_idle,
    output logic [AddrW-1:0]       rom_address,
    output logic                   rom_ce,
    input  logic [COEFF_WIDTH-1:0] rom_q,
    output logic [COEFF_WIDTH-1:0] output_V_din,
    input  logic                   output_V_full_n,
    output logic                   output_V_write
`ifdef WEIGHT_CTRL_PERF_EN
    ,
    output logic [31:0]            stall_cycles
`endif
);

    localparam logic [AddrW-1:0]     LastAddr = AddrW'(KERN_SIZE - 1);
    localparam logic [PassWidth-1:0] LastPass =
        PassWidth'((NUM_PASSES == 0) ? 0 : NUM_PASSES - 1);
    localparam bit Forever = (NUM_PASSES == 0);

    state_e               r_state;
    state_e               w_state_next;
    logic [AddrW-1:0]     r_addr;
    logic [AddrW-1:0]     w_addr_next;
    logic [PassWidth-1:0] r_pass;
    logic [PassWidth-1:0] w_pass_next;
    logic                 r_inflight;
    logic [1:0]           w_occ;
    logic                 w_pop;
    logic [2:0]           w_used;

    // Slots already claimed once this cycle's pop is accounted for.
    assign w_pop  = (w_occ != 2'd0) && output_V_full_n;
    assign w_used = 3'(w_occ) + 3'(r_inflight) - 3'(w_pop);
    assign rom_ce = (r_state == StRun) && (w_used < 3'd2);

    assign rom_address    = r_addr;
    assign output_V_write = w_pop;

    always_comb begin
        w_state_next = r_state;
        w_addr_next  = r_addr;
        w_pass_next  = r_pass;
        ap_idle      = 1'b0;
        ap_done      = 1'b0;
        unique case (r_state)
            StIdle: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    w_state_next = StRun;
                    w_addr_next  = '0;
                    w_pass_next  = '0;
                end
            end
            StRun: begin
                if (rom_ce) begin
                    if (r_addr == LastAddr) begin
                        if (!Forever && (r_pass == LastPass)) begin
                            w_state_next = StDrain;
                        end else begin
                            w_addr_next = '0;
                            w_pass_next = r_pass + 1'b1;
                        end
                    end else begin
                        w_addr_next = r_addr + 1'b1;
                    end
                end
            end
            StDrain: begin
                if ((w_occ == 2'd0) && !r_inflight) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                ap_done      = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state    <= StIdle;
            r_addr     <= '0;
            r_pass     <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_addr     <= w_addr_next;
            r_pass     <= w_pass_next;
            r_inflight <= rom_ce;
        end
    end

    // ROM data lands one cycle after issue, so the in-flight flag is the push strobe.
    weight_stream_ctrl_skid_buf #(
        .Width(COEFF_WIDTH)
    ) u_skid_buf (
        .i_clk (ap_clk),
        .i_rst (ap_rst),
        .i_push(r_inflight),
        .i_pop (w_pop),
        .i_din (rom_q),
        .o_dout(output_V_din),
        .o_occ (w_occ)
    );

`ifdef WEIGHT_CTRL_PERF_EN
    logic [31:0] r_stall;

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_stall <= '0;
        end else if ((r_state == StIdle) && ap_start) begin
            r_stall <= '0;
        end else if ((w_occ != 2'd0) && !output_V_full_n && (r_stall != '1)) begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_weight_stream_ctrl.sv
// Bench for weight_stream_ctrl: five instances with different sizes/pass counts, one
// count-based reference model and a per-cycle compare process.
module tb_weight_stream_ctrl;

    localparam int NInst = 5;

    function automatic int ks_of(input int i);
        return (i == 2) ? 288 : (i == 4) ? 1 : 4;
    endfunction

    function automatic int np_of(input int i);
        return (i == 1) ? 3 : (i == 2) ? 2 : (i == 3) ? 0 : (i == 4) ? 2 : 1;
    endfunction

    logic        ap_clk;
    logic        rst_a   [NInst];
    logic        start_a [NInst];
    logic        fn_a    [NInst];
    logic        wr_a    [NInst];
    logic        done_a  [NInst];
    logic        idle_a  [NInst];
    logic        ce_a    [NInst];
    logic [15:0] din_a   [NInst];
    logic [8:0]  addr_a  [NInst];
`ifdef WEIGHT_CTRL_PERF_EN
    logic [31:0] stall_a [NInst];
`endif

    int cyc;
    int n_err;
    int n_chk;
    int t0;
    int phase;
    int req_seq;
    int ack_seq;
    bit timeout_flag;

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NInst; g++) begin : g_dut
        localparam int unsigned KS = (g == 2) ? 288 : (g == 4) ? 1 : 4;
        localparam int unsigned NP = (g == 1) ? 3 : (g == 2) ? 2 : (g == 3) ? 0 :
                                     (g == 4) ? 2 : 1;
        localparam int unsigned AW = (KS > 1) ? $clog2(KS) : 1;
        logic [AW-1:0] w_addr;
        logic [15:0]   r_q;

        // ROM model: word i holds i + 10, one-cycle read latency.
        always @(posedge ap_clk) if (ce_a[g]) r_q <= 16'(w_addr) + 16'd10;
        assign addr_a[g] = 9'(w_addr);

        weight_stream_ctrl #(
            .KERN_SIZE  (KS),
            .COEFF_WIDTH(16),
            .NUM_PASSES (NP)
        ) u_dut (
            .ap_clk         (ap_clk),
            .ap_rst         (rst_a[g]),
            .ap_start       (start_a[g]),
            .ap_done        (done_a[g]),
            .ap_idle        (idle_a[g]),
            .rom_address    (w_addr),
            .rom_ce         (ce_a[g]),
            .rom_q          (r_q),
            .output_V_din   (din_a[g]),
            .output_V_full_n(fn_a[g]),
            .output_V_write (wr_a[g])
`ifdef WEIGHT_CTRL_PERF_EN
            ,
            .stall_cycles   (stall_a[g])
`endif
        );
    end

    // Model state: counts of issued/written words and buffer occupancy.
    bit idle_m     [NInst];
    int occ_m      [NInst];
    int infl_m     [NInst];
    int n_iss      [NInst];
    int n_wr       [NInst];
    bit empty_prev [NInst];
    int stall_m    [NInst];
    // Per-run observations of the DUT, used by the literal phase checks.
    int first_wr   [NInst];
    int last_wr    [NInst];
    int done_at    [NInst];
    int done_cnt   [NInst];
    int run_wr     [NInst];
    int log_v      [NInst][16];

    task automatic chk(input int inst, input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s inst%0d cyc%0d: got %0d expected %0d", nm, inst, cyc, act, exp);
        end
    endtask

    task automatic phase_checks();
        chk(phase, "timeout", int'(timeout_flag), 0);
        case (phase)
            1: begin
                chk(0, "p1_first_wr", first_wr[0] - t0, 2);
                chk(0, "p1_done_at", done_at[0] - t0, 7);
                chk(0, "p1_done_cnt", done_cnt[0], 1);
                for (int k = 0; k < 4; k++) chk(0, "p1_word", log_v[0][k], 10 + k);
                chk(0, "p1_idle", int'(idle_a[0]), 1);
            end
            2: begin
                chk(1, "p2_first_wr", first_wr[1] - t0, 2);
                chk(1, "p2_span", last_wr[1] - first_wr[1], 11);
                chk(1, "p2_count", run_wr[1], 12);
                chk(1, "p2_done_at", done_at[1] - t0, 15);
                chk(1, "p2_done_cnt", done_cnt[1], 1);
                chk(1, "p2_word4", log_v[1][4], 10);
                chk(1, "p2_word11", log_v[1][11], 13);
            end
            3: begin
                chk(0, "p3_first_wr", first_wr[0] - t0, 2);
                chk(0, "p3_last_wr", last_wr[0] - t0, 11);
                chk(0, "p3_done_at", done_at[0] - t0, 13);
                chk(0, "p3_count", run_wr[0], 4);
                chk(0, "p3_word1", log_v[0][1], 11);
                chk(0, "p3_word3", log_v[0][3], 13);
`ifdef WEIGHT_CTRL_PERF_EN
                chk(0, "p3_stall", int'(stall_a[0]), 6);
`endif
            end
            4: begin
                chk(2, "p4_count", run_wr[2], 576);
                chk(2, "p4_done_cnt", done_cnt[2], 1);
            end
            5: begin
                chk(0, "p5_count", run_wr[0], 4);
                chk(0, "p5_word0", log_v[0][0], 10);
                chk(0, "p5_done_at", done_at[0] - t0, 7);
                chk(0, "p5_done_cnt", done_cnt[0], 1);
            end
            6: begin
                chk(3, "p6_done_cnt", done_cnt[3], 0);
                chk(3, "p6_progress", int'(run_wr[3] > 4), 1);
            end
            7: begin
                chk(4, "p7_count", run_wr[4], 2);
                chk(4, "p7_done_cnt", done_cnt[4], 1);
                chk(4, "p7_word0", log_v[4][0], 10);
                chk(4, "p7_word1", log_v[4][1], 10);
            end
            default: ;
        endcase
    endtask

    always @(negedge ap_clk) begin : p_check
        int  ks;
        int  np;
        bit  left;
        bit  e_wr;
        bit  e_ce;
        bit  e_done;
        if (req_seq != ack_seq) begin
            phase_checks();
            ack_seq = req_seq;
        end
        for (int i = 0; i < NInst; i++) begin
            ks = ks_of(i);
            np = np_of(i);
            if (rst_a[i]) begin
                chk(i, "rst_write", int'(wr_a[i]), 0);
                chk(i, "rst_ce", int'(ce_a[i]), 0);
                chk(i, "rst_done", int'(done_a[i]), 0);
                chk(i, "rst_idle", int'(idle_a[i]), 1);
                chk(i, "rst_din", int'(din_a[i]), 0);
`ifdef WEIGHT_CTRL_PERF_EN
                chk(i, "rst_stall", int'(stall_a[i]), 0);
`endif
                idle_m[i]     = 1'b1;
                occ_m[i]      = 0;
                infl_m[i]     = 0;
                n_iss[i]      = 0;
                n_wr[i]       = 0;
                empty_prev[i] = 1'b0;
                stall_m[i]    = 0;
            end else begin
                left   = (np == 0) || (n_iss[i] < ks * np);
                e_wr   = (occ_m[i] > 0) && fn_a[i];
                e_ce   = !idle_m[i] && left && (occ_m[i] + infl_m[i] - int'(e_wr) < 2);
                e_done = empty_prev[i];
                chk(i, "write", int'(wr_a[i]), int'(e_wr));
                chk(i, "rom_ce", int'(ce_a[i]), int'(e_ce));
                chk(i, "done", int'(done_a[i]), int'(e_done));
                chk(i, "idle", int'(idle_a[i]), int'(idle_m[i]));
                if (occ_m[i] > 0) chk(i, "din", int'(din_a[i]), (n_wr[i] % ks) + 10);
                if (e_ce && ce_a[i]) chk(i, "addr", int'(addr_a[i]), n_iss[i] % ks);
`ifdef WEIGHT_CTRL_PERF_EN
                chk(i, "stall", int'(stall_a[i]), stall_m[i]);
                if (occ_m[i] > 0 && !fn_a[i]) stall_m[i]++;
`endif
                if (wr_a[i]) begin
                    if (run_wr[i] == 0) first_wr[i] = cyc;
                    last_wr[i] = cyc;
                    if (run_wr[i] < 16) log_v[i][run_wr[i]] = int'(din_a[i]);
                    run_wr[i]++;
                end
                if (done_a[i]) begin
                    done_cnt[i]++;
                    done_at[i] = cyc;
                end
                empty_prev[i] = !idle_m[i] && (np != 0) && !left && (occ_m[i] == 0) &&
                                (infl_m[i] == 0) && !e_done;
                occ_m[i]  = occ_m[i] + infl_m[i] - int'(e_wr);
                infl_m[i] = int'(e_ce);
                n_iss[i]  = n_iss[i] + int'(e_ce);
                n_wr[i]   = n_wr[i] + int'(e_wr);
                if (e_done) begin
                    idle_m[i] = 1'b1;
                end else if (idle_m[i] && start_a[i]) begin
                    idle_m[i]   = 1'b0;
                    n_iss[i]    = 0;
                    n_wr[i]     = 0;
                    stall_m[i]  = 0;
                    first_wr[i] = -1;
                    last_wr[i]  = -1;
                    done_at[i]  = -1;
                    done_cnt[i] = 0;
                    run_wr[i]   = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic kick(input int i);
        start_a[i] = 1'b1;
        step();
        start_a[i] = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input int i, input int bound);
        int k;
        k = 0;
        while (done_cnt[i] == 0 && k < bound) begin
            step();
            k++;
        end
        if (done_cnt[i] == 0) timeout_flag = 1'b1;
        step();
        step();
    endtask

    task automatic phase_check(input int p);
        phase = p;
        req_seq++;
        step();
        timeout_flag = 1'b0;
    endtask

    initial begin
        int k;
        for (int i = 0; i < NInst; i++) begin
            rst_a[i]   = 1'b1;
            start_a[i] = 1'b0;
            fn_a[i]    = 1'b1;
        end
        step();
        step();
        for (int i = 0; i < NInst; i++) rst_a[i] = 1'b0;
        step();

        // Straight single pass.
        kick(0);
        wait_done(0, 50);
        phase_check(1);

        // Three back-to-back passes.
        kick(1);
        wait_done(1, 100);
        phase_check(2);

        // Downstream full for relative cycles 3..8.
        kick(0);
        for (int c = 0; c < 30; c++) begin
            fn_a[0] = !(c >= 3 && c <= 8);
            step();
        end
        fn_a[0] = 1'b1;
        phase_check(3);

        // Large ROM, two passes, random back-pressure.
        kick(2);
        k = 0;
        while (done_cnt[2] == 0 && k < 4000) begin
            fn_a[2] = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        if (done_cnt[2] == 0) timeout_flag = 1'b1;
        fn_a[2] = 1'b1;
        step();
        step();
        phase_check(4);

        // Reset after the second word, then a clean restart.
        kick(0);
        k = 0;
        while (run_wr[0] < 2 && k < 50) begin
            step();
            k++;
        end
        if (run_wr[0] < 2) timeout_flag = 1'b1;
        rst_a[0] = 1'b1;
        step();
        rst_a[0] = 1'b0;
        step();
        kick(0);
        wait_done(0, 50);
        phase_check(5);

        // Endless sweep with a start pulse that must be ignored.
        kick(3);
        for (int c = 0; c < 40; c++) begin
            fn_a[3]    = 1'($urandom_range(0, 1));
            start_a[3] = (c == 20);
            step();
        end
        start_a[3] = 1'b0;
        fn_a[3]    = 1'b1;
        phase_check(6);
        rst_a[3] = 1'b1;
        step();
        rst_a[3] = 1'b0;
        step();

        // Single-word ROM, two passes.
        kick(4);
        k = 0;
        while (done_cnt[4] == 0 && k < 200) begin
            fn_a[4] = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        if (done_cnt[4] == 0) timeout_flag = 1'b1;
        fn_a[4] = 1'b1;
        step();
        step();
        phase_check(7);

        step();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
